// File: rtl/intt_16point_if.sv
// Stream bundle for intt_16point: coefficient input stream and time-domain output stream.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface intt_16point_if;
  logic [6:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/intt_16point.sv
// 16-point inverse NTT over Z_97: bit-reversed load, one radix-2 DIT butterfly per cycle,
// natural-order output scaled by N^-1 = 91.
module intt_16point (
  input  logic          clk,
  input  logic          rst_n,
  intt_16point_if.slave bus,
  output logic          busy
);
  localparam logic [6:0]  Q    = 7'd97;
  localparam logic [13:0] NInv = 14'd91;

  typedef enum logic [1:0] {StLoad, StCompute, StOut} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] ocnt_q, ocnt_d;
  logic [1:0] s_q, s_d;
  logic [2:0] b_q, b_d;
  logic [6:0] mem_q [16];
  logic [6:0] mem_d [16];

  logic              in_hs, out_hs;
  logic [6:0]        in_red;
  logic [3:0]        m, j, top, bot;
  logic [2:0]        tw_idx;
  logic [6:0]        tw, a, bv, t, sum_m, diff_m, odata;
  logic [13:0]       prod, oprod;
  logic [7:0]        sum;
  logic signed [7:0] diff;

  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // Powers of w^-1 = 85 mod 97.
  function automatic logic [6:0] winv(input logic [2:0] idx);
    logic [6:0] r;
    unique case (idx)
      3'd0: r = 7'd1;
      3'd1: r = 7'd85;
      3'd2: r = 7'd47;
      3'd3: r = 7'd18;
      3'd4: r = 7'd75;
      3'd5: r = 7'd70;
      3'd6: r = 7'd33;
      3'd7: r = 7'd89;
    endcase
    return r;
  endfunction

  assign in_hs  = bus.in_valid & bus.in_ready;
  assign out_hs = bus.out_valid & bus.out_ready;
  assign in_red = (bus.in_data >= Q) ? bus.in_data - Q : bus.in_data;

  // Butterfly addressing and arithmetic for the current (stage, index).
  always_comb begin
    m      = 4'd1 << s_q;
    j      = {1'b0, b_q} & (m - 4'd1);
    top    = 4'((({1'b0, b_q} >> s_q) << ({1'b0, s_q} + 3'd1)) + j);
    bot    = top + m;
    tw_idx = j[2:0] << (2'd3 - s_q);
    tw     = winv(tw_idx);
    a      = mem_q[top];
    bv     = mem_q[bot];
    prod   = 14'(tw) * 14'(bv);
    t      = 7'(prod % 14'd97);
    sum    = {1'b0, a} + {1'b0, t};
    sum_m  = (sum >= 8'd97) ? 7'(sum - 8'd97) : sum[6:0];
    diff   = $signed({1'b0, a}) - $signed({1'b0, t});
    diff_m = (diff < 8'sd0) ? 7'(diff + 8'sd97) : diff[6:0];
    oprod  = NInv * 14'(mem_q[ocnt_q]);
    odata  = 7'(oprod % 14'd97);
  end

  // Datapath next state; all counters wrap naturally at their last value.
  always_comb begin
    cnt_d  = cnt_q;
    ocnt_d = ocnt_q;
    s_d    = s_q;
    b_d    = b_q;
    mem_d  = mem_q;
    unique case (state_q)
      StLoad: begin
        if (in_hs) begin
          mem_d[bitrev4(cnt_q)] = in_red;
          cnt_d                 = cnt_q + 4'd1;
        end
      end
      StCompute: begin
        mem_d[top] = sum_m;
        mem_d[bot] = diff_m;
        b_d        = b_q + 3'd1;
        if (b_q == 3'd7) s_d = s_q + 2'd1;
      end
      StOut: begin
        if (out_hs) ocnt_d = ocnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      s_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ocnt_q  <= ocnt_d;
      s_q     <= s_d;
      b_q     <= b_d;
    end
  end

  // Coefficient store needs no reset: a full load always precedes its use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (in_hs && cnt_q == 4'd15) state_d = StCompute;
      StCompute: if (s_q == 2'd3 && b_q == 3'd7) state_d = StOut;
      StOut:     if (out_hs && ocnt_q == 4'd15) state_d = StLoad;
      default:   state_d = StLoad;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StLoad);
    bus.out_valid = (state_q == StOut);
    bus.out_data  = (state_q == StOut) ? odata : 7'd0;
    bus.out_last  = (state_q == StOut) && (ocnt_q == 4'd15);
    busy          = (state_q != StLoad);
  end
endmodule

// File: tb/tb_intt_16point.sv
// Directed and round-trip bench for intt_16point: impulse, constant, range reduction,
// single bin with backpressure, reset mid-compute and forward/inverse round trips.
module tb_intt_16point;
  typedef logic [6:0] vec_t [16];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t v, e, x;

  intt_16point_if bus ();

  intt_16point u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pow_mod(input int base, input int ex);
    int r = 1;
    for (int i = 0; i < ex; i++) r = (r * base) % 97;
    return r;
  endfunction

  // Golden forward NTT with w = 8, direct O(N^2) form.
  task automatic fwd_ntt(input vec_t vin, output vec_t vout);
    for (int k = 0; k < 16; k++) begin
      int acc = 0;
      for (int n = 0; n < 16; n++) acc = (acc + int'(vin[n]) * pow_mod(8, (n * k) % 16)) % 97;
      vout[k] = 7'(acc);
    end
  endtask

  task automatic send_vec(input vec_t vin, input bit stall);
    int i = 0;
    int guard = 0;
    while (i < 16) begin
      @(posedge clk); #1;
      bus.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = vin[i];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) i++;
      guard++;
      if (guard > 2000) begin
        check_eq("send_timeout", i, 16);
        return;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_vec(input vec_t exp, input bit stall, input int hold_at, input string tag);
    int i = 0;
    int guard = 0;
    bit held = 1'b0;
    while (i < 16) begin
      @(posedge clk); #1;
      if (i == hold_at && !held) begin
        held = 1'b1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check_eq($sformatf("%s_hold_data", tag), int'(bus.out_data), int'(exp[i]));
          check_eq($sformatf("%s_hold_valid", tag), int'(bus.out_valid), 1);
          check_eq($sformatf("%s_hold_in_ready", tag), int'(bus.in_ready), 0);
          @(posedge clk); #1;
        end
      end
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        check_eq($sformatf("%s_x%0d", tag, i), int'(bus.out_data), int'(exp[i]));
        check_eq($sformatf("%s_last%0d", tag, i), int'(bus.out_last), int'(i == 15));
        if (i < 15) check_eq($sformatf("%s_in_ready%0d", tag, i), int'(bus.in_ready), 0);
        i++;
      end
      guard++;
      if (guard > 2000) begin
        check_eq($sformatf("%s_recv_timeout", tag), i, 16);
        return;
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq($sformatf("%s_in_ready_after", tag), int'(bus.in_ready), 1);
  endtask

  // Called right after the 16th input handshake edge; out_valid must rise 32 edges later.
  task automatic measure_latency();
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", n, 32);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 7'd0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", int'(bus.in_ready), 1);
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_out_data", int'(bus.out_data), 0);
    check_eq("rst_out_last", int'(bus.out_last), 0);
    check_eq("rst_busy", int'(busy), 0);

    // Impulse: all outputs equal N^-1.
    v = '{default: 7'd0};
    v[0] = 7'd1;
    e = '{default: 7'd91};
    send_vec(v, 1'b0);
    check_eq("busy_compute", int'(busy), 1);
    check_eq("in_ready_compute", int'(bus.in_ready), 0);
    measure_latency();
    recv_vec(e, 1'b0, -1, "impulse");

    // Constant spectrum and its out-of-range twin collapse to a single time sample.
    v = '{default: 7'd1};
    e = '{default: 7'd0};
    e[0] = 7'd1;
    send_vec(v, 1'b0);
    recv_vec(e, 1'b0, -1, "const");
    v = '{default: 7'd98};
    send_vec(v, 1'b0);
    recv_vec(e, 1'b0, -1, "reduce");

    // Single bin X[1] = 1 with a 10-cycle output stall mid-stream.
    v = '{default: 7'd0};
    v[1] = 7'd1;
    for (int n = 0; n < 16; n++) e[n] = 7'((91 * pow_mod(85, n)) % 97);
    send_vec(v, 1'b0);
    recv_vec(e, 1'b0, 6, "bin1");

    // Reset during stage 2 of the butterfly network.
    v = '{default: 7'd0};
    v[0] = 7'd5;
    send_vec(v, 1'b0);
    repeat (18) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("rstmid_in_ready", int'(bus.in_ready), 1);
    check_eq("rstmid_busy", int'(busy), 0);
    check_eq("rstmid_out_valid", int'(bus.out_valid), 0);
    v = '{default: 7'd0};
    v[0] = 7'd1;
    e = '{default: 7'd91};
    send_vec(v, 1'b0);
    recv_vec(e, 1'b0, -1, "post_rst");

    // Round trips through the golden forward transform with random stalls.
    for (int r = 0; r < 200; r++) begin
      for (int k = 0; k < 16; k++) v[k] = 7'($urandom_range(0, 96));
      fwd_ntt(v, x);
      send_vec(x, 1'b1);
      recv_vec(v, 1'b1, -1, $sformatf("rt%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
